fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline. Holds the program counter, drives the instruction-memory address, and loads the IF/ID pipeline register that feeds decode (`InstrD`, `PCPlus4D`). It honours the hazard unit's `StallF`/`StallD` and the decode-stage branch redirect (`PCSrcD`/`PCBranchD`). It inserts bubbles on memory wait, branch flush and out-of-range fetch, and keeps saturating fetch/bubble counters for the datapath bench.

---
 rtl/fetch_stage.sv | 75 +++++++
 tb/tb_fetch_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, instruction-memory address and the IF/ID register.
// Inserts bubbles on memory wait, branch flush and faulting fetch; keeps saturating fetch/bubble counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int unsigned IMEM_WORDS = 28,
  parameter int unsigned COUNT_W    = 16
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               StallF,
  input  logic               StallD,
  input  logic               PCSrcD,
  input  logic [31:0]        PCBranchD,
  output logic [31:0]        imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               imem_ready,
  output logic [31:0]        PCF,
  output logic [31:0]        PCPlus4F,
  output logic [31:0]        InstrD,
  output logic [31:0]        PCPlus4D,
  output logic               ValidD,
  output logic               fetch_fault,
  output logic [COUNT_W-1:0] InstrCount,
  output logic [COUNT_W-1:0] BubbleCount
);

  localparam logic [32:0]        PC_LIMIT  = 33'(IMEM_WORDS) * 33'd4;
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
  localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

  logic fetchOk;
  logic loadValid;

  assign imem_addr   = PCF;
  assign PCPlus4F    = PCF + 32'd4;
  assign fetch_fault = ({1'b0, PCF} >= PC_LIMIT) || (PCF[1:0] != 2'b00);
  assign fetchOk     = imem_ready && !fetch_fault;
  // A redirect flushes whatever was fetched this cycle.
  assign loadValid   = !PCSrcD && fetchOk;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      PCF <= RESET_PC;
    end else if (!StallF) begin
      if (PCSrcD)       PCF <= PCBranchD;
      else if (fetchOk) PCF <= PCPlus4F;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      InstrD   <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (!StallD) begin
      InstrD   <= loadValid ? imem_rdata : 32'h0;
      PCPlus4D <= PCPlus4F;
      ValidD   <= loadValid;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      InstrCount  <= '0;
      BubbleCount <= '0;
    end else if (!StallD) begin
      if (loadValid) begin
        if (InstrCount != COUNT_MAX) InstrCount <= InstrCount + COUNT_ONE;
      end else begin
        if (BubbleCount != COUNT_MAX) BubbleCount <= BubbleCount + COUNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized stimulus against a behavioural model.
module tb_fetch_stage;

  localparam int WORDS = 28;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          reset;
  logic          StallF, StallD, PCSrcD, imem_ready;
  logic [31:0]   PCBranchD, imem_addr, imem_rdata;
  logic [31:0]   PCF, PCPlus4F, InstrD, PCPlus4D;
  logic          ValidD, fetch_fault;
  logic [CW-1:0] InstrCount, BubbleCount;

  logic [31:0] mem [WORDS];

  logic [31:0] mPC, mInstr, mPc4D;
  logic        mValid;
  int          mIcnt, mBcnt;
  int          errors = 0;
  int          checks = 0;

  fetch_stage #(.RESET_PC(32'h0), .IMEM_WORDS(WORDS), .COUNT_W(CW)) dut (
    .CLK(CLK), .reset(reset), .StallF(StallF), .StallD(StallD),
    .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .PCF(PCF),
    .PCPlus4F(PCPlus4F), .InstrD(InstrD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .fetch_fault(fetch_fault),
    .InstrCount(InstrCount), .BubbleCount(BubbleCount)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (a < 32'(WORDS * 4)) return mem[a[31:2]];
    return 32'hDEAD_BEEF;
  endfunction

  // Garbage words beyond memory make an ignored-fault bug visible.
  assign imem_rdata = memRead(imem_addr);

  function automatic logic modelFault(input logic [31:0] pc);
    return (pc >= 32'(WORDS * 4)) || (pc % 4 != 0);
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    mPC = 32'h0; mInstr = 32'h0; mPc4D = 32'h0; mValid = 1'b0;
    mIcnt = 0; mBcnt = 0;
  endtask

  // One clock of the fetch rules: a fetch succeeds only when memory is ready and the PC is legal;
  // IF/ID gets the word or a bubble, the PC follows redirect > wait/fault hold > sequential.
  task automatic modelStep();
    logic        ok;
    logic [31:0] nextSeq;
    ok      = imem_ready && !modelFault(mPC);
    nextSeq = mPC + 32'd4;
    if (!StallD) begin
      if (ok && !PCSrcD) begin
        mInstr = mem[mPC / 4];
        mValid = 1'b1;
        if (mIcnt < CMAX) mIcnt++;
      end else begin
        mInstr = 32'h0;
        mValid = 1'b0;
        if (mBcnt < CMAX) mBcnt++;
      end
      mPc4D = nextSeq;
    end
    if (!StallF) begin
      if (PCSrcD)  mPC = PCBranchD;
      else if (ok) mPC = nextSeq;
    end
  endtask

  task automatic checkAll(input string tag);
    checkVal({tag, ".PCF"},      PCF,         mPC);
    checkVal({tag, ".PCPlus4F"}, PCPlus4F,    mPC + 32'd4);
    checkVal({tag, ".imemAddr"}, imem_addr,   mPC);
    checkVal({tag, ".InstrD"},   InstrD,      mInstr);
    checkVal({tag, ".PCPlus4D"}, PCPlus4D,    mPc4D);
    checkVal({tag, ".ValidD"},   32'(ValidD), 32'(mValid));
    checkVal({tag, ".fault"},    32'(fetch_fault), 32'(modelFault(mPC)));
    checkVal({tag, ".icnt"},     32'(InstrCount),  32'(mIcnt));
    checkVal({tag, ".bcnt"},     32'(BubbleCount), 32'(mBcnt));
  endtask

  task automatic cycle(input string tag);
    @(posedge CLK);
    modelStep();
    #1;
    checkAll(tag);
  endtask

  task automatic redirect(input logic [31:0] target, input string tag);
    PCSrcD = 1'b1; PCBranchD = target;
    cycle(tag);
    PCSrcD = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = 32'h2000_0000 + 32'(i);
    StallF = 0; StallD = 0; PCSrcD = 0; PCBranchD = 0; imem_ready = 1;
    reset = 0;
    #2;
    modelReset();
    checkAll("reset");
    @(negedge CLK); reset = 1;

    repeat (5) cycle("seq");
    checkVal("seq.word4", InstrD, 32'h2000_0004);
    checkVal("seq.pc4d", PCPlus4D, 32'd20);
    checkVal("seq.icnt5", 32'(InstrCount), 32'd5);

    redirect(32'd8, "toPc8");
    StallF = 1; StallD = 1;
    repeat (3) cycle("stall");
    checkVal("stall.pc", PCF, 32'd8);
    StallF = 0; StallD = 0;
    cycle("unstall");
    checkVal("unstall.word2", InstrD, 32'h2000_0002);

    redirect(32'h40, "br40");
    checkVal("br40.pc", PCF, 32'h40);
    checkVal("br40.valid", 32'(ValidD), 32'd0);
    cycle("brTarget");
    checkVal("brTarget.word16", InstrD, 32'h2000_0010);

    redirect(32'd4, "toPc4");
    imem_ready = 0;
    cycle("wait1");
    checkVal("wait.pcHeld", PCF, 32'd4);
    redirect(32'd0, "waitRedirect");
    checkVal("waitRedirect.pc", PCF, 32'd0);
    imem_ready = 1;

    redirect(32'd100, "toPc100");
    repeat (3) cycle("runToEnd");
    checkVal("oob.fault", 32'(fetch_fault), 32'd1);
    repeat (2) cycle("oobPark");
    checkVal("oob.pcHeld", PCF, 32'd112);
    redirect(32'd0, "oobRecover");
    checkVal("oobRecover.fault", 32'(fetch_fault), 32'd0);
    cycle("oobResume");
    checkVal("oobResume.word0", InstrD, 32'h2000_0000);
    redirect(32'h6, "misalign");
    checkVal("misalign.fault", 32'(fetch_fault), 32'd1);
    cycle("misalignPark");
    redirect(32'd0, "misalignRecover");

    for (int n = 0; n < 400; n++) begin
      StallF     = ($urandom_range(0, 99) < 15);
      StallD     = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) == 1) : StallF;
      imem_ready = ($urandom_range(0, 3) != 0);
      PCSrcD     = ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 7) == 0) PCBranchD = 32'($urandom_range(0, 130));
      else                           PCBranchD = {28'd0, 4'd0} + 32'($urandom_range(0, WORDS - 1)) * 4;
      cycle("rand");
    end

    StallF = 0; StallD = 0; imem_ready = 1;
    redirect(32'd16, "preRst");
    PCSrcD = 1; PCBranchD = 32'h40;
    #3;
    reset = 0;
    #1;
    modelReset();
    checkAll("asyncRst");
    checkVal("asyncRst.pc", PCF, 32'd0);
    PCSrcD = 0;
    @(negedge CLK); reset = 1;

    repeat (20) cycle("sat");
    checkVal("sat.icnt", 32'(InstrCount), 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
